// File: rtl/execute_stage_mc.sv
// EX stage: forwarding, 1-cycle ALU, branch compare, optional iterative mul/div (`MULDIV_EN`) feeding EX/MEM.
// Latency: single-cycle ops 1 cycle; mul/div occupy EX for XLEN+2 cycles.
// Backpressure: BusyE stalls IF/ID/EX while mul/div runs; EX/MEM takes bubbles meanwhile.
module execute_stage_mc #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             ResultSrcE,
    input  logic             ALUSrcE,
    input  logic             BranchE,
    input  logic [2:0]       BranchCondE,
    input  logic [3:0]       ALUControlE,
    input  logic [XLEN-1:0]  RD1_E,
    input  logic [XLEN-1:0]  RD2_E,
    input  logic [XLEN-1:0]  Imm_Ext_E,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCPlus4E,
    input  logic [RADDR-1:0] RD_E,
    input  logic [XLEN-1:0]  ResultW,
    input  logic [1:0]       ForwardA_E,
    input  logic [1:0]       ForwardB_E,
    output logic             BusyE,
    output logic             PCSrcE,
    output logic [XLEN-1:0]  PCTargetE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             ResultSrcM,
    output logic [RADDR-1:0] RD_M,
    output logic [XLEN-1:0]  PCPlus4M,
    output logic [XLEN-1:0]  WriteDataM,
    output logic [XLEN-1:0]  ALU_ResultM
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_res, ex_result;
    logic [SHW-1:0]  shamt;
    logic            br_cond;

    always_comb begin
        case (ForwardA_E)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALU_ResultM;
            default: fwd_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    assign src_b     = ALUSrcE ? Imm_Ext_E : fwd_b;
    assign shamt     = src_b[SHW-1:0];
    assign PCTargetE = PCE + Imm_Ext_E;

    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            4'b0000: alu_res = fwd_a + src_b;
            4'b0001: alu_res = fwd_a - src_b;
            4'b0010: alu_res = fwd_a & src_b;
            4'b0011: alu_res = fwd_a | src_b;
            4'b0100: alu_res = fwd_a ^ src_b;
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
            4'b0110: alu_res = {{(XLEN-1){1'b0}}, fwd_a < src_b};
            4'b0111: alu_res = fwd_a << shamt;
            4'b1100: alu_res = fwd_a >> shamt;
            4'b1101: alu_res = XLEN'($signed(fwd_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Comparator always sees register operands, never the immediate.
    always_comb begin
        br_cond = 1'b0;
        case (BranchCondE)
            3'b000:  br_cond = (fwd_a == fwd_b);
            3'b001:  br_cond = (fwd_a != fwd_b);
            3'b100:  br_cond = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_cond = (fwd_a <  fwd_b);
            3'b111:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign PCSrcE = BranchE & br_cond & ~BusyE & ~rst;

`ifdef MULDIV_EN
    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

    md_state_t       state, state_nx;
    logic [XLEN-1:0] md_acc, md_mq, md_opd, div_sub;
    logic [1:0]      md_op;
    logic [SHW:0]    md_cnt;
    logic            is_md, md_busy, div_ge;
    logic [XLEN:0]   mul_sum, div_shift;

    assign is_md     = (ALUControlE[3:2] == 2'b10);
    assign mul_sum   = {1'b0, md_acc} + (md_mq[0] ? {1'b0, md_opd} : '0);
    assign div_shift = {md_acc, md_mq[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, md_opd});
    assign div_sub   = XLEN'(div_shift - {1'b0, md_opd});

    always_comb begin
        state_nx = state;
        md_busy  = 1'b0;
        case (state)
            MD_IDLE: if (is_md) begin
                md_busy  = 1'b1;
                state_nx = MD_RUN;
            end
            MD_RUN: begin
                md_busy = 1'b1;
                if (md_cnt == (SHW+1)'(XLEN-1)) state_nx = MD_DONE;
            end
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
    end

    // acc holds product-high / remainder, mq holds product-low / quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            md_acc <= '0;
            md_mq  <= '0;
            md_opd <= '0;
            md_op  <= '0;
            md_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == MD_IDLE && is_md) begin
                md_op  <= ALUControlE[1:0];
                md_cnt <= '0;
                md_acc <= '0;
                md_mq  <= fwd_a;
                md_opd <= src_b;
            end else if (state == MD_RUN) begin
                md_cnt <= md_cnt + 1'b1;
                if (md_op[1]) begin
                    md_acc <= div_ge ? div_sub : div_shift[XLEN-1:0];
                    md_mq  <= {md_mq[XLEN-2:0], div_ge};
                end else begin
                    md_acc <= mul_sum[XLEN:1];
                    md_mq  <= {mul_sum[0], md_mq[XLEN-1:1]};
                end
            end
        end
    end

    assign BusyE     = md_busy & ~rst;
    assign ex_result = (state == MD_DONE) ? (md_op[0] ? md_acc : md_mq) : alu_res;
`else
    assign BusyE     = 1'b0;
    assign ex_result = alu_res;
`endif

    always_ff @(posedge clk) begin
        if (rst || BusyE) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= ex_result;
        end
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Bench for execute_stage_mc: scoreboard of expected EX/MEM records, plus combinational branch checks.
module tb_execute_stage_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
    logic [2:0]  BranchCondE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        BusyE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
    logic [4:0]  RD_M;

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic        rs;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] alu;
    } mrec_t;

    mrec_t sb[$];
    mrec_t got, exp;
    int    total = 0;
    int    bad   = 0;

    execute_stage_mc #(.XLEN(32), .RADDR(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .BranchCondE(BranchCondE),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .BusyE(BusyE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic mrec_t m_now();
        return mrec_t'({RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM});
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << sh;
            4'd12:   return a >> sh;
            4'd13:   return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [1:0] fa, input logic [1:0] fb,
                         input logic alusrc, input logic rw, input logic mw, input logic rs,
                         input logic [4:0] rd);
        ALUControlE = op;  RD1_E = a;  RD2_E = b;  Imm_Ext_E = imm;
        ForwardA_E = fa;   ForwardB_E = fb;  ALUSrcE = alusrc;
        RegWriteE = rw;    MemWriteE = mw;   ResultSrcE = rs;  RD_E = rd;
        BranchE = 1'b0;    BranchCondE = 3'b000;
        PCE = $urandom & 32'hFFFF_FFFC;
        PCPlus4E = PCE + 32'd4;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1000, 32'd7, 32'd7, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9);
        BranchE = 1'b1;
        BranchCondE = 3'b000;
        step();
        step();
        total++;
        if (m_now() !== '0) begin bad++; $display("FAIL reset_m got=%h exp=0", m_now()); end
        total++;
        if (BusyE !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BusyE); end
        total++;
        if (PCSrcE !== 1'b0) begin bad++; $display("FAIL reset_pcsrc got=%b exp=0", PCSrcE); end
        rst = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step();
    endtask

    task automatic test_alu();
        logic [31:0] prev, a, b, bb, res;
        logic [3:0]  ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15};
        logic [3:0]  op;
        logic [1:0]  fa, fb;
        logic        as, rw, mw;

        drive(4'd0, 32'h8, 32'h8, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3);
        sb.push_back(mrec_t'({1'b1, 1'b0, 1'b0, 5'd3, PCPlus4E, 32'h8, 32'h10}));
        step();
        exp = sb.pop_front(); got = m_now(); total++;
        if (got !== exp) begin bad++; $display("FAIL add_plain got=%h exp=%h", got, exp); end

        drive(4'd0, 32'hDEAD_BEEF, 32'h5, 32'h0, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
        sb.push_back(mrec_t'({1'b1, 1'b0, 1'b0, 5'd4, PCPlus4E, 32'h5, 32'h15}));
        step();
        exp = sb.pop_front(); got = m_now(); total++;
        if (got !== exp) begin bad++; $display("FAIL add_fwd_m got=%h exp=%h", got, exp); end

        // B forwarded from W, then overridden by the immediate; store data keeps the forwarded value.
        ResultW = 32'h100;
        drive(4'd0, 32'h1, 32'h7, 32'h20, 2'b11, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
        sb.push_back(mrec_t'({1'b0, 1'b1, 1'b1, 5'd5, PCPlus4E, 32'h100, 32'h21}));
        step();
        exp = sb.pop_front(); got = m_now(); total++;
        if (got !== exp) begin bad++; $display("FAIL add_imm_fwd_w got=%h exp=%h", got, exp); end
        prev = 32'h21;

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 11)];
            fa = 2'($urandom_range(0, 3));
            fb = 2'($urandom_range(0, 3));
            as = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            ResultW = $urandom;
            drive(op, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom, fa, fb, as, rw, mw, 1'b0, 5'($urandom_range(0, 31)));
            a  = (fa == 2'b01) ? ResultW : (fa == 2'b10) ? prev : RD1_E;
            bb = (fb == 2'b01) ? ResultW : (fb == 2'b10) ? prev : RD2_E;
            b  = as ? Imm_Ext_E : bb;
            res = ref_alu(op, a, b);
            sb.push_back(mrec_t'({rw, mw, 1'b0, RD_E, PCPlus4E, bb, res}));
            step();
            exp = sb.pop_front(); got = m_now(); total++;
            if (got !== exp) begin bad++; $display("FAIL alu_rand op=%0d got=%h exp=%h", op, got, exp); end
            prev = res;
        end
    endtask

    task automatic test_branch();
        logic [2:0]  cond [11] = '{3'b100, 3'b110, 3'b000, 3'b000, 3'b001, 3'b101, 3'b101, 3'b111, 3'b111, 3'b000, 3'b000};
        logic [31:0] va   [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'd5};
        logic [31:0] vb   [11] = '{32'd1, 32'd1, 32'd5, 32'd6, 32'd6, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'd5};
        logic        en   [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        want [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive(4'd0, va[i], vb[i], 32'h40, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
            BranchE = en[i];
            BranchCondE = cond[i];
            PCE = 32'h1000;
            #1;
            total++;
            if (PCSrcE !== want[i]) begin bad++; $display("FAIL branch_%0d got=%b exp=%b", i, PCSrcE, want[i]); end
        end
        total++;
        if (PCTargetE !== 32'h1040) begin bad++; $display("FAIL pctarget got=%h exp=00001040", PCTargetE); end
        PCE = 32'hFFFF_FFF0;
        Imm_Ext_E = 32'h20;
        #1;
        total++;
        if (PCTargetE !== 32'h10) begin bad++; $display("FAIL pctarget_wrap got=%h exp=00000010", PCTargetE); end
        BranchE = 1'b0;
        step();
    endtask

`ifdef MULDIV_EN
    task automatic test_muldiv();
        logic [3:0]  op  [8] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd10, 4'd11, 4'd8, 4'd9};
        logic [31:0] va  [8] = '{32'h1234_5678, 32'h1234_5678, 32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb  [8] = '{32'h10, 32'h10, 32'd0, 32'd0, 32'h8000_0001, 32'h8000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] res [8] = '{32'h2345_6780, 32'h1, 32'hFFFF_FFFF, 32'd100, 32'h1, 32'h7FFF_FFFE, 32'h1, 32'hFFFF_FFFE};
        int busy;
        // Ops issue back-to-back: each starts on the cycle right after the previous DONE edge.
        for (int i = 0; i < 8; i++) begin
            drive(op[i], va[i], vb[i], 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'(i + 1));
            #1;
            total++;
            if (BusyE !== 1'b1) begin bad++; $display("FAIL md_busy_start_%0d got=%b exp=1", i, BusyE); end
            busy = 0;
            while (BusyE === 1'b1 && busy < 100) begin
                sb.push_back('0);
                step();
                exp = sb.pop_front(); got = m_now(); total++;
                if (got !== exp) begin bad++; $display("FAIL md_bubble_%0d got=%h exp=%h", i, got, exp); end
                busy++;
                RD1_E = $urandom;
                #1;
            end
            total++;
            if (busy != 33) begin bad++; $display("FAIL md_busy_len_%0d got=%0d exp=33", i, busy); end
            sb.push_back(mrec_t'({1'b1, 1'b0, 1'b0, 5'(i + 1), PCPlus4E, vb[i], res[i]}));
            step();
            exp = sb.pop_front(); got = m_now(); total++;
            if (got !== exp) begin bad++; $display("FAIL md_result_%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid();
        drive(4'd8, 32'h1234_5678, 32'h10, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7);
        for (int i = 0; i < 11; i++) step();
        total++;
        if (BusyE !== 1'b1) begin bad++; $display("FAIL rstmid_running got=%b exp=1", BusyE); end
        rst = 1'b1;
        drive(4'd0, 32'h3, 32'h4, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);
        step();
        rst = 1'b0;
        #1;
        total++;
        if (m_now() !== '0) begin bad++; $display("FAIL rstmid_m got=%h exp=0", m_now()); end
        total++;
        if (BusyE !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", BusyE); end
        sb.push_back(mrec_t'({1'b1, 1'b0, 1'b0, 5'd8, PCPlus4E, 32'h4, 32'h7}));
        step();
        exp = sb.pop_front(); got = m_now(); total++;
        if (got !== exp) begin bad++; $display("FAIL rstmid_add got=%h exp=%h", got, exp); end
    endtask
`else
    task automatic test_no_muldiv();
        for (int i = 8; i < 12; i++) begin
            drive(4'(i), 32'h1234_5678, 32'h10, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'(i));
            #1;
            total++;
            if (BusyE !== 1'b0) begin bad++; $display("FAIL nomd_busy_%0d got=%b exp=0", i, BusyE); end
            sb.push_back(mrec_t'({1'b1, 1'b0, 1'b0, 5'(i), PCPlus4E, 32'h10, 32'h0}));
            step();
            exp = sb.pop_front(); got = m_now(); total++;
            if (got !== exp) begin bad++; $display("FAIL nomd_result_%0d got=%h exp=%h", i, got, exp); end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        ResultW = '0;
        drive(4'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        test_reset();
        test_alu();
        test_branch();
`ifdef MULDIV_EN
        test_muldiv();
        test_reset_mid();
`else
        test_no_muldiv();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/execute_stage_mc.md
# execute_stage_mc

Parametrised execute stage for the 5-stage pipeline: operand forwarding, a single-cycle ALU, a six-way branch comparator and an iterative multi-cycle multiply/divide unit. It sits between the ID/EX and EX/MEM boundaries and owns the EX/MEM pipeline register. It raises a busy signal that the hazard unit uses to stall IF/ID/EX while a multiply or divide is running.

## Interface
- `XLEN`, default 32: datapath width. Must be ≥ 8 and a power of two.
- `RADDR`, default 5: register-address width.
- `clk` input 1: pipeline clock.
- `rst` input 1: synchronous, active-high reset.
- `RegWriteE`, `MemWriteE`, `ResultSrcE`, `ALUSrcE`, `BranchE` input 1 each: ID/EX control.
- `BranchCondE` input 3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- `ALUControlE` input 4: operation code (see Operation).
- `RD1_E`, `RD2_E`, `Imm_Ext_E`, `PCE`, `PCPlus4E` input XLEN: operands and PC values.
- `RD_E` input RADDR: destination register.
- `ResultW` input XLEN: writeback result used for forwarding.
- `ForwardA_E`, `ForwardB_E` input 2: 00 register, 01 `ResultW`, 10 `ALU_ResultM`, 11 register.
- `BusyE` output 1: a multi-cycle op occupies EX; hazard unit stalls IF/ID/EX.
- `PCSrcE` output 1: branch taken.
- `PCTargetE` output XLEN: `PCE + Imm_Ext_E`, modulo 2^XLEN.
- `RegWriteM`, `MemWriteM`, `ResultSrcM` output 1 each: EX/MEM control.
- `RD_M` output RADDR.
- `PCPlus4M`, `WriteDataM`, `ALU_ResultM` output XLEN.

## Operation
- **Operand A**: forward mux output.
- **Operand B**: forward mux output, then replaced by `Imm_Ext_E` when `ALUSrcE` = 1.
- **`WriteDataM`**: captures the forwarded B value, taken before the immediate mux.
- **Single-cycle ALU codes**:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1100 SRL, 1101 SRA. Shift amount is B[log2(XLEN)-1:0].
  - 1110, 1111: result 0.
  - All arithmetic wraps modulo 2^XLEN.
- **Multi-cycle codes**: 1000 MUL (low XLEN bits), 1001 MULHU (high XLEN bits, unsigned), 1010 DIVU, 1011 REMU.
- **Branch**: the comparator uses the forwarded A and B register values (never the immediate).
  - `PCSrcE` = `BranchE` & condition.
  - `PCSrcE` is 0 while `rst` is high and while `BusyE` is high.
- **MD FSM states**: IDLE, RUN, DONE.
  - IDLE: a multi-cycle code in EX drives `BusyE` = 1 combinationally. Forwarded operands are latched at the edge. Counter is cleared. Next state is RUN.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. `BusyE` = 1. After exactly XLEN steps the next state is DONE.
  - DONE: `BusyE` = 0. The MD result drives the EX result. EX/MEM loads it at the edge. Next state is IDLE.
- **Bubbles**: while `BusyE` = 1, EX/MEM loads a bubble (`RegWriteM` = `MemWriteM` = `ResultSrcM` = 0, `RD_M` = 0; data fields don't-care, driven 0).
- **Operand capture**: operands are latched once in IDLE. Forwarding-source changes during RUN (e.g. the M bubble) do not affect the result.
- **Divide by zero**: DIVU returns all ones; REMU returns the dividend. Either completes in the normal XLEN+2 cycles.

## Timing
- **Single-cycle ops**: 1-cycle latency. EX inputs at edge n appear on the M outputs after edge n+1.
- **Multi-cycle ops**:
  - The instruction occupies EX for XLEN+2 cycles: 1 IDLE, XLEN RUN, 1 DONE.
  - `BusyE` is high for the first XLEN+1 of those cycles.
  - Result appears on `ALU_ResultM` after the DONE edge.
- **Back-to-back multi-cycle ops**: after DONE the FSM returns to IDLE, so the next op starts immediately. No extra gap cycle.
- **Reset**:
  - All M outputs are 0; `BusyE` = 0; `PCSrcE` = 0; FSM is IDLE; counter and MD registers are 0.
  - `rst` during RUN or DONE aborts the operation. Nothing is written to EX/MEM except the reset values.
- `PCTargetE` is purely combinational and valid every cycle.

## Configuration
- `MULDIV_EN` defined: MD FSM and datapath are compiled in, as above.
- `MULDIV_EN` undefined:
  - No FSM and no MD registers.
  - `BusyE` is tied 0.
  - Codes 1000–1011 complete in one cycle with result 0.

## Test plan
- **ADD with M forward**: ADD with `ForwardA_E` = 10, `ALU_ResultM` = 0x10, `RD2_E` = 0x5 → `ALU_ResultM` = 0x15 one cycle later, `RegWriteM` follows `RegWriteE`.
- **Signed vs unsigned branch**: BLT with A = 0xFFFFFFFF, B = 1 → `PCSrcE` = 1. BLTU with the same values → `PCSrcE` = 0. `PCTargetE` = `PCE` + imm.
- **MUL timing**: MUL 0x12345678 × 0x10 → `BusyE` high 33 cycles, 33 bubbles in M, then `ALU_ResultM` = 0x23456780 and MULHU of the same operands = 0x1.
- **Divide by zero**: DIVU 100 / 0 → 0xFFFFFFFF. REMU 100 / 0 → 100. Both after 34 cycles in EX.
- **Reset mid-operation**: `rst` asserted at RUN step 10 → next cycle all M outputs 0 and `BusyE` 0. A following ADD completes normally.
- **Build without `MULDIV_EN`**: MUL → `BusyE` stays 0, `ALU_ResultM` = 0 after 1 cycle.
